// File: rtl/elastic_reg_pkg.sv
// Shared types and helpers for the elastic register slice.
package elastic_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  // Occupancy counter width: must represent 0..2*depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/elastic_stage_sv.sv
// One two-entry skid stage; ready is a pure function of the local state register.
module elastic_stage_sv
  import elastic_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  stage_state_t     r_state;
  stage_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_accept;
  logic             w_take;
  logic             w_ld_main;
  logic             w_ld_skid;
  logic             w_main_from_skid;

  assign in_ready  = (r_state == ST_EMPTY) || (r_state == ST_BUSY);
  assign out_valid = (r_state == ST_BUSY)  || (r_state == ST_FULL);
  assign out_data  = r_main;
  assign w_accept  = in_valid && in_ready;
  assign w_take    = out_valid && out_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_ld_main        = 1'b0;
    w_ld_skid        = 1'b0;
    w_main_from_skid = 1'b0;
    // A flush suppresses every transfer on this edge.
    if (clr) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_BUSY;
            w_ld_main   = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_take) begin
            w_ld_main = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_take) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_take) begin
            w_state_nxt      = ST_BUSY;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main) begin
        r_main <= in_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= in_data;
      end
    end
  end

endmodule

// File: rtl/elastic_reg_sv.sv
// DEPTH-stage elastic register slice built from skid stages.
// Optional occupancy output enabled by defining ELASTIC_REG_OCC_EN.
module elastic_reg_sv
  import elastic_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef ELASTIC_REG_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  logic [WIDTH-1:0] w_data  [DEPTH+1];
  logic             w_valid [DEPTH+1];
  logic             w_ready [DEPTH+1];

  assign w_data[0]      = in_data;
  assign w_valid[0]     = in_valid;
  assign in_ready       = w_ready[0];
  assign out_data       = w_data[DEPTH];
  assign out_valid      = w_valid[DEPTH];
  assign w_ready[DEPTH] = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    elastic_stage_sv #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .resetn   (resetn),
      .clr      (clr),
      .in_data  (w_data[k]),
      .in_valid (w_valid[k]),
      .in_ready (w_ready[k]),
      .out_data (w_data[k+1]),
      .out_valid(w_valid[k+1]),
      .out_ready(w_ready[k+1])
    );
  end

`ifdef ELASTIC_REG_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] r_occ;
  logic             w_in_xfer;
  logic             w_out_xfer;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign occ        = r_occ;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_occ <= '0;
    end else if (clr) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_elastic_reg_sv.sv
// Directed and randomised checks of elastic_reg_sv (WIDTH=8, DEPTH=2).
module tb_elastic_reg_sv;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             resetn;
  logic             clr;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
`ifdef ELASTIC_REG_OCC_EN
  logic [$clog2(2*DEPTH+1)-1:0] occ;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [WIDTH-1:0] q[$];
  logic             r_stall = 1'b0;
  logic [WIDTH-1:0] r_hold  = '0;

  elastic_reg_sv #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef ELASTIC_REG_OCC_EN
    ,
    .occ      (occ)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold-stability monitor, sampling pre-edge values.
  always @(posedge clk) begin
    if (!resetn || clr) begin
      q.delete();
      r_stall <= 1'b0;
    end else begin
      if (r_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(r_hold));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_empty", 32'd0, 32'd1);
        else chk("sb_order", 32'(out_data), 32'(q.pop_front()));
        n_out <= n_out + 1;
      end
      if (in_valid && in_ready) q.push_back(in_data);
      r_stall <= out_valid && !out_ready;
      r_hold  <= out_data;
    end
  end

  initial begin
    int acc;
    int sent;
    int n_out0;
    logic rdy;

    resetn = 1'b0; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h00);
    resetn = 1'b1;
    tick();

    // Two words held, then async reset mid-cycle.
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_valid = 1'b0; tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #3 resetn = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'h00);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
`ifdef ELASTIC_REG_OCC_EN
    chk("arst_occ", 32'(occ), 32'd0);
`endif
    tick();
    resetn = 1'b1;
    tick();

    // Streaming at full rate: latency DEPTH, one word per cycle.
    out_ready = 1'b1;
    for (int t = 0; t < 18; t++) begin
      in_valid = (t < 16);
      in_data  = 8'(t + 1);
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_out_valid", 32'(out_valid), (t >= 2) ? 32'd1 : 32'd0);
      if (t >= 2) chk("stream_out_data", 32'(out_data), 32'(t - 1));
      tick();
    end
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Fill with downstream blocked: exactly 2*DEPTH words accepted.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'hA0 + acc);
      #1;
      rdy = in_ready;
      tick();
      if (rdy) acc++;
    end
    chk("full_accepted", 32'(acc), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
`ifdef ELASTIC_REG_OCC_EN
    chk("full_occ", 32'(occ), 32'd4);
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'(8'hA0 + j));
      if (j == 1) chk("drain_in_ready_lo", 32'(in_ready), 32'd0);
      if (j == 2) chk("drain_in_ready_hi", 32'(in_ready), 32'd1);
      tick();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Random handshakes against the scoreboard.
    n_out0 = n_out;
    sent = 0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (sent == 2000 && q.size() == 0 && !out_valid) break;
      if (!in_valid && sent < 2000 && ($urandom % 2 == 1)) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
      end
      out_ready = 1'($urandom % 2);
      #1;
      rdy = in_valid && in_ready;
      tick();
      if (rdy) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    chk("rnd_sent", 32'(sent), 32'd2000);
    chk("rnd_delivered", 32'(n_out - n_out0), 32'd2000);
    chk("rnd_residue", 32'(q.size()), 32'd0);

    // Flush with three words held.
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    in_valid = 1'b1;
    in_data = 8'h31; tick();
    in_data = 8'h32; tick();
    in_data = 8'h33; tick();
`ifdef ELASTIC_REG_OCC_EN
    chk("pre_clr_occ", 32'(occ), 32'd3);
`endif
    clr = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    #1;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
`ifdef ELASTIC_REG_OCC_EN
    chk("clr_occ", 32'(occ), 32'd0);
`endif
    in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("post_clr_lat1", 32'(out_valid), 32'd0);
    tick();
    chk("post_clr_valid", 32'(out_valid), 32'd1);
    chk("post_clr_data", 32'(out_data), 32'h55);
    tick();
    chk("post_clr_empty", 32'(out_valid), 32'd0);

    // Async reset while full; nothing may reappear afterwards.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hC0 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("rf_full", 32'(in_ready), 32'd0);
    #3 resetn = 1'b0;
    #1;
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    chk("rf_out_data", 32'(out_data), 32'h00);
    chk("rf_in_ready", 32'(in_ready), 32'd1);
`ifdef ELASTIC_REG_OCC_EN
    chk("rf_occ", 32'(occ), 32'd0);
`endif
    tick();
    resetn = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rf_idle_valid", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
